// File: rtl/peak_find.sv
// peak_find -- streaming local-maximum detector for a frame of signed 8-bit samples.
//
// Pulls N_SAMPLES samples from an upstream source using a rd/rdy handshake,
// keeps a two-sample history and reports every local peak with a one-cycle
// PkClk strobe together with its index (PeakX) and sign-extended value (PeakY).
// pk_done is raised once the last sample has been consumed.
//
// Optional feature macro: PEAKFIND_THRESH_EN
//   defined   -> a peak must also satisfy x[k-1] >= THRESH (signed)
//   undefined -> every local maximum is reported
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous reset, active HIGH (name kept for compatibility)
//   rdy       in   source valid; FreqIn is sampled on edges where rd && rdy
//   FreqIn    in   8-bit signed sample
//   rd        out  sample request, high while samples remain
//   pk_done   out  frame complete, sticky until reset
//   PkClk     out  one-cycle peak strobe
//   addr_out  out  index of next requested sample (= samples consumed)
//   PeakX     out  index of the last detected peak
//   PeakY     out  value of the last detected peak, sign-extended to 14 bits
module peak_find #(
  parameter int                 N_SAMPLES = 1000,
  parameter logic signed [7:0]  THRESH    = 8'sd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic signed [7:0] FreqIn,
  output logic              rd,
  output logic              pk_done,
  output logic              PkClk,
  output logic [11:0]       addr_out,
  output logic [11:0]       PeakX,
  output logic [13:0]       PeakY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [11:0] LAST_IDX = 12'(N_SAMPLES - 1);

  state_t            r_state;
  logic signed [7:0] r_x1;   // x[k-1]
  logic signed [7:0] r_x2;   // x[k-2]

  logic w_consume;
  logic w_thresh_ok;
  logic w_is_peak;

  assign w_consume = (r_state == S_RUN) && rdy;

`ifdef PEAKFIND_THRESH_EN
  assign w_thresh_ok = (r_x1 >= THRESH);
`else
  // Folds to constant 1: THRESH has no effect in this build.
  assign w_thresh_ok = 1'b1 | THRESH[7];
`endif

  // The history is only fully populated once k >= 2, which also guarantees
  // sample 0 is never reported. Sample N-1 is never evaluated as x[k-1].
  assign w_is_peak = (addr_out >= 12'd2) && (r_x1 > r_x2) &&
                     (r_x1 >= FreqIn) && w_thresh_ok;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state  <= S_IDLE;
      r_x1     <= 8'sd0;
      r_x2     <= 8'sd0;
      rd       <= 1'b0;
      pk_done  <= 1'b0;
      PkClk    <= 1'b0;
      addr_out <= 12'd0;
      PeakX    <= 12'd0;
      PeakY    <= 14'd0;
    end else begin
      PkClk <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state <= S_RUN;
          rd      <= 1'b1;
        end
        S_RUN: begin
          if (w_consume) begin
            r_x1     <= FreqIn;
            r_x2     <= r_x1;
            addr_out <= addr_out + 12'd1;
            if (w_is_peak) begin
              PkClk <= 1'b1;
              PeakX <= addr_out - 12'd1;
              PeakY <= {{6{r_x1[7]}}, r_x1};
            end
            if (addr_out == LAST_IDX) begin
              r_state <= S_DONE;
              rd      <= 1'b0;
              pk_done <= 1'b1;
            end
          end
        end
        default: begin
          // Frame finished: idle until reset.
          r_state <= S_DONE;
          rd      <= 1'b0;
          pk_done <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peak_find.sv
module tb_peak_find;

  localparam int                NS [5] = '{5, 3, 4, 100, 1000};
  localparam logic signed [7:0] TH [5] = '{8'sd8, 8'h80, 8'sd0, 8'sd0, 8'h80};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rdy = 1'b0;
  logic signed [7:0] din = 8'sd0;

  logic        rd_w   [5];
  logic        done_w [5];
  logic        pk_w   [5];
  logic [11:0] addr_w [5];
  logic [11:0] px_w   [5];
  logic [13:0] py_w   [5];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          npk     = 0;
  logic [11:0] lx      = 12'd0;
  logic [13:0] ly      = 14'd0;
  logic [11:0] fx      = 12'd0;

  always #5 clk = ~clk;

  // Instance 0: N=5, THRESH=8; 1: N=3; 2: N=4; 3: N=100; 4: N=1000.
  // All instances share stimulus and reset; each test observes one of them.
  for (genvar gi = 0; gi < 5; gi++) begin : g_dut
    peak_find #(.N_SAMPLES(NS[gi]), .THRESH(TH[gi])) u_dut (
      .clk      (clk),
      .rst_n    (rst),
      .rdy      (rdy),
      .FreqIn   (din),
      .rd       (rd_w[gi]),
      .pk_done  (done_w[gi]),
      .PkClk    (pk_w[gi]),
      .addr_out (addr_w[gi]),
      .PeakX    (px_w[gi]),
      .PeakY    (py_w[gi])
    );
  end

  // One clock edge; record any peak strobe seen on instance idx.
  task automatic cyc(input int idx);
    @(posedge clk);
    #1;
    if (pk_w[idx] === 1'b1) begin
      if (npk == 0) fx = px_w[idx];
      npk++;
      lx = px_w[idx];
      ly = py_w[idx];
      $display("[TB] inst%0d peak x=%0d y=%h t=%0t", idx, lx, ly, $time);
    end
  endtask

  task automatic feed(input int idx, input logic signed [7:0] v);
    din = v;
    rdy = 1'b1;
    cyc(idx);
  endtask

  task automatic do_reset();
    rdy = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    npk = 0;
    lx  = 12'd0;
    ly  = 14'd0;
    fx  = 12'd0;
  endtask

  task automatic test_reset();
    rdy = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({rd_w[0], done_w[0], pk_w[0]} !== 3'b000 || addr_w[0] !== 12'd0 ||
        px_w[0] !== 12'd0 || py_w[0] !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_state: rd=%b done=%b pk=%b addr=%0d px=%0d py=%h, want all 0",
               rd_w[0], done_w[0], pk_w[0], addr_w[0], px_w[0], py_w[0]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    n_tests++;
    if (rd_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_before_edge: rd=%b, want 0", rd_w[0]);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (rd_w[0] !== 1'b1 || addr_w[0] !== 12'd0) begin
      n_fail++;
      $display("FAIL rd_rise: rd=%b addr=%0d, want rd=1 addr=0", rd_w[0], addr_w[0]);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_triangle();
    logic signed [7:0] v [5];
    v = '{8'sd0, 8'sd10, 8'sd20, 8'sd10, 8'sd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      feed(0, v[i]);
      if (i == 3) begin
        n_tests++;
        if (pk_w[0] !== 1'b1 || px_w[0] !== 12'd2) begin
          n_fail++;
          $display("FAIL tri_latency: pk=%b px=%0d, want pk=1 px=2", pk_w[0], px_w[0]);
        end
      end
    end
    n_tests++;
    if (done_w[0] !== 1'b1 || rd_w[0] !== 1'b0 || addr_w[0] !== 12'd5) begin
      n_fail++;
      $display("FAIL tri_done: done=%b rd=%b addr=%0d, want 1 0 5", done_w[0], rd_w[0], addr_w[0]);
    end
    // rdy while done must be ignored
    feed(0, 8'sd77);
    feed(0, 8'sd1);
    rdy = 1'b0;
    n_tests++;
    if (npk !== 1 || lx !== 12'd2 || ly !== 14'd20) begin
      n_fail++;
      $display("FAIL tri_peak: count=%0d x=%0d y=%h, want 1 2 0014", npk, lx, ly);
    end
    n_tests++;
    if (addr_w[0] !== 12'd5 || done_w[0] !== 1'b1 || pk_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL tri_hold: addr=%0d done=%b pk=%b, want 5 1 0", addr_w[0], done_w[0], pk_w[0]);
    end
    $display("[TB] test_triangle done");
  endtask

  task automatic test_negative();
    do_reset();
    feed(1, -8'sd50);
    feed(1, -8'sd10);
    feed(1, -8'sd40);
    rdy = 1'b0;
    n_tests++;
    if (npk !== 1 || lx !== 12'd1 || ly !== 14'h3FF6 || done_w[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL neg_peak: count=%0d x=%0d y=%h done=%b, want 1 1 3ff6 1", npk, lx, ly, done_w[1]);
    end
    $display("[TB] test_negative done");
  endtask

  task automatic test_plateau();
    do_reset();
    feed(2, 8'sd1);
    feed(2, 8'sd5);
    feed(2, 8'sd5);
    feed(2, 8'sd2);
    rdy = 1'b0;
    cyc(2);
    n_tests++;
    if (npk !== 1 || lx !== 12'd1 || ly !== 14'd5) begin
      n_fail++;
      $display("FAIL plateau: count=%0d x=%0d y=%h, want 1 1 0005", npk, lx, ly);
    end
    $display("[TB] test_plateau done");
  endtask

  task automatic test_ramp();
    do_reset();
    for (int i = 0; i < 99; i++) feed(3, 8'(i));
    n_tests++;
    if (done_w[3] !== 1'b0 || addr_w[3] !== 12'd99 || rd_w[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_early: done=%b addr=%0d rd=%b, want 0 99 1", done_w[3], addr_w[3], rd_w[3]);
    end
    feed(3, 8'sd99);
    rdy = 1'b0;
    n_tests++;
    if (npk !== 0 || done_w[3] !== 1'b1 || addr_w[3] !== 12'd100) begin
      n_fail++;
      $display("FAIL ramp: peaks=%0d done=%b addr=%0d, want 0 1 100", npk, done_w[3], addr_w[3]);
    end
    $display("[TB] test_ramp done");
  endtask

  task automatic test_stall();
    do_reset();
    feed(1, 8'sd0);
    din = 8'sd9;
    rdy = 1'b0;
    cyc(1);
    cyc(1);
    n_tests++;
    if (addr_w[1] !== 12'd1) begin
      n_fail++;
      $display("FAIL stall_addr: addr=%0d, want 1", addr_w[1]);
    end
    feed(1, 8'sd9);
    n_tests++;
    if (addr_w[1] !== 12'd2) begin
      n_fail++;
      $display("FAIL stall_resume: addr=%0d, want 2", addr_w[1]);
    end
    feed(1, 8'sd3);
    rdy = 1'b0;
    n_tests++;
    if (npk !== 1 || lx !== 12'd1 || ly !== 14'd9 || done_w[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_peak: count=%0d x=%0d y=%h done=%b, want 1 1 0009 1", npk, lx, ly, done_w[1]);
    end
    $display("[TB] test_stall done");
  endtask

  task automatic test_thresh();
    logic signed [7:0] v [5];
    v = '{8'sd0, 8'sd5, 8'sd0, 8'sd12, 8'sd0};
    do_reset();
    for (int i = 0; i < 5; i++) feed(0, v[i]);
    rdy = 1'b0;
`ifdef PEAKFIND_THRESH_EN
    n_tests++;
    if (npk !== 1 || lx !== 12'd3 || ly !== 14'd12) begin
      n_fail++;
      $display("FAIL thresh_on: count=%0d x=%0d y=%h, want 1 3 000c", npk, lx, ly);
    end
`else
    n_tests++;
    if (npk !== 2 || fx !== 12'd1 || lx !== 12'd3 || ly !== 14'd12) begin
      n_fail++;
      $display("FAIL thresh_off: count=%0d first=%0d last=%0d y=%h, want 2 1 3 000c", npk, fx, lx, ly);
    end
`endif
    $display("[TB] test_thresh done");
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 400; i++) feed(4, (i % 4 == 1) ? 8'sd20 : 8'sd0);
    n_tests++;
    if (addr_w[4] !== 12'd400 || lx !== 12'd397) begin
      n_fail++;
      $display("FAIL pre_reset: addr=%0d lastpk=%0d, want 400 397", addr_w[4], lx);
    end
    rdy = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({rd_w[4], done_w[4], pk_w[4]} !== 3'b000 || addr_w[4] !== 12'd0 ||
        px_w[4] !== 12'd0 || py_w[4] !== 14'd0) begin
      n_fail++;
      $display("FAIL async_reset: rd=%b done=%b pk=%b addr=%0d px=%0d py=%h, want all 0",
               rd_w[4], done_w[4], pk_w[4], addr_w[4], px_w[4], py_w[4]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    npk = 0;
    for (int i = 0; i < 1000; i++) feed(4, (i % 4 == 1) ? 8'sd20 : 8'sd0);
    rdy = 1'b0;
    n_tests++;
    if (npk !== 250 || fx !== 12'd1 || lx !== 12'd997 || ly !== 14'd20) begin
      n_fail++;
      $display("FAIL restart_peaks: count=%0d first=%0d last=%0d y=%h, want 250 1 997 0014",
               npk, fx, lx, ly);
    end
    n_tests++;
    if (done_w[4] !== 1'b1 || addr_w[4] !== 12'd1000 || rd_w[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_done: done=%b addr=%0d rd=%b, want 1 1000 0", done_w[4], addr_w[4], rd_w[4]);
    end
    $display("[TB] test_mid_reset done");
  endtask

  initial begin
    test_reset();
    test_triangle();
    test_negative();
    test_plateau();
    test_ramp();
    test_stall();
    test_thresh();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
